// File: rtl/append_buffer_pkg.sv
// -----------------------------------------------------------------------------
// append_buffer_pkg
// Shared address-formation constants for the 16-bit processor.
//   HI_W   : width of the PC-derived upper field of a jump target
//   IMM_W  : width of the immediate lower field of a jump target
//   ADDR_W : full address width (HI_W + IMM_W)
//   addr_t : address-wide vector type used by the PC and branch logic
// -----------------------------------------------------------------------------
package append_buffer_pkg;

    localparam int HI_W   = 4;
    localparam int IMM_W  = 12;
    localparam int ADDR_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage : append_buffer_pkg

// File: rtl/append_concat.sv
// -----------------------------------------------------------------------------
// append_concat
// Purely combinational field concatenation: {hi_field, lo_field}.
// Ports:
//   hi_field  in  HI_W    upper field (occupies the MSBs of the result)
//   lo_field  in  IMM_W   lower field (occupies the LSBs of the result)
//   addr      out ADDR_W  concatenated address, zero latency
// -----------------------------------------------------------------------------
module append_concat
    import append_buffer_pkg::*;
#(
    parameter int HI_W   = append_buffer_pkg::HI_W,
    parameter int IMM_W  = append_buffer_pkg::IMM_W,
    parameter int ADDR_W = append_buffer_pkg::ADDR_W
) (
    input  logic [HI_W-1:0]   hi_field,
    input  logic [IMM_W-1:0]  lo_field,
    output logic [ADDR_W-1:0] addr
);

    generate
        if (HI_W + IMM_W != ADDR_W) begin : g_width_check
            $error("append_concat: HI_W + IMM_W must equal ADDR_W");
        end
    endgenerate

    assign addr = {hi_field, lo_field};

endmodule : append_concat

// File: rtl/append_buffer.sv
// -----------------------------------------------------------------------------
// append_buffer
// Jump-target address former. The upper PC bits are concatenated with the
// jump immediate to form the target. The combinational target feeds the
// PC-select mux directly; a registered copy with a sticky valid flag serves
// pipelined or multi-cycle consumers.
// Ports:
//   clk           in  1       rising-edge clock
//   reset         in  1       synchronous active-high reset
//   load          in  1       capture enable for the registered target
//   Upper_4_PC    in  HI_W    upper bits of the current PC
//   Lower_12_Imm  in  IMM_W   immediate field of the jump instruction
//   Append_Out    out ADDR_W  combinational target, independent of clk/reset
//   Target_Q      out ADDR_W  registered target (0 after reset)
//   Target_Valid  out 1       set by the first load after reset, held until reset
// -----------------------------------------------------------------------------
module append_buffer
    import append_buffer_pkg::*;
#(
    parameter int HI_W   = append_buffer_pkg::HI_W,
    parameter int IMM_W  = append_buffer_pkg::IMM_W,
    parameter int ADDR_W = append_buffer_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HI_W-1:0]   Upper_4_PC,
    input  logic [IMM_W-1:0]  Lower_12_Imm,
    output logic [ADDR_W-1:0] Append_Out,
    output logic [ADDR_W-1:0] Target_Q,
    output logic              Target_Valid
);

    generate
        if (HI_W + IMM_W != ADDR_W) begin : g_width_check
            $error("append_buffer: HI_W + IMM_W must equal ADDR_W");
        end
    endgenerate

    logic [ADDR_W-1:0] target_p0;
    logic [ADDR_W-1:0] target_p1;
    logic              vld_p1;

    // Stage p0: combinational concatenation, exported unregistered.
    append_concat #(
        .HI_W   (HI_W),
        .IMM_W  (IMM_W),
        .ADDR_W (ADDR_W)
    ) u_concat (
        .hi_field (Upper_4_PC),
        .lo_field (Lower_12_Imm),
        .addr     (target_p0)
    );

    assign Append_Out = target_p0;

    // Stage p1: captured target. Reset takes priority over a coincident load,
    // and the valid flag is sticky until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_p1 <= '0;
            vld_p1    <= 1'b0;
        end else if (load) begin
            target_p1 <= target_p0;
            vld_p1    <= 1'b1;
        end
    end

    assign Target_Q     = target_p1;
    assign Target_Valid = vld_p1;

endmodule : append_buffer

// File: tb/tb_append_buffer.sv
// -----------------------------------------------------------------------------
// tb_append_buffer
// Directed self-checking bench for append_buffer.
// -----------------------------------------------------------------------------
module tb_append_buffer;

    logic        clk;
    logic        clk_run;
    logic        reset;
    logic        load;
    logic [3:0]  Upper_4_PC;
    logic [11:0] Lower_12_Imm;
    logic [15:0] Append_Out;
    logic [15:0] Target_Q;
    logic        Target_Valid;

    int n_vec;
    int n_bad;

    append_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .Upper_4_PC   (Upper_4_PC),
        .Lower_12_Imm (Lower_12_Imm),
        .Append_Out   (Append_Out),
        .Target_Q     (Target_Q),
        .Target_Valid (Target_Valid)
    );

    // Clock stays low until clk_run is raised, so the combinational path
    // can be exercised with no clock running.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic comb_vec(input string tag, input logic [3:0] hi, input logic [11:0] lo,
                            input logic [15:0] exp);
        Upper_4_PC   = hi;
        Lower_12_Imm = lo;
        #1;
        chk(tag, Append_Out, exp);
    endtask

    // Advance one full cycle: inputs driven at negedge are sampled at the
    // following posedge and outputs are checked at the next negedge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        clk_run      = 1'b0;
        reset        = 1'b0;
        load         = 1'b0;
        Upper_4_PC   = 4'h0;
        Lower_12_Imm = 12'h000;

        // Combinational path, no clock.
        comb_vec("comb_zero",  4'h0, 12'h000, 16'h0000);
        comb_vec("comb_4567",  4'h4, 12'h567, 16'h4567);
        comb_vec("iso_hi",     4'hA, 12'h000, 16'hA000);
        comb_vec("iso_lo",     4'h0, 12'hABC, 16'h0ABC);
        comb_vec("iso_ones",   4'hF, 12'hFFF, 16'hFFFF);
        comb_vec("iso_alt",    4'h5, 12'hAAA, 16'h5AAA);

        // Start clock, reset for two cycles.
        clk_run = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_q",   Target_Q, 16'h0000);
        chk("rst_vld", {15'd0, Target_Valid}, 16'h0000);

        // Single capture.
        reset        = 1'b0;
        load         = 1'b1;
        Upper_4_PC   = 4'h3;
        Lower_12_Imm = 12'h21F;
        cycle();
        chk("cap_q",   Target_Q, 16'h321F);
        chk("cap_vld", {15'd0, Target_Valid}, 16'h0001);

        // Hold with load low while the combinational output follows inputs.
        load = 1'b0;
        comb_vec("hold_comb", 4'h9, 12'h001, 16'h9001);
        cycle();
        chk("hold_q",   Target_Q, 16'h321F);
        chk("hold_vld", {15'd0, Target_Valid}, 16'h0001);

        // Back-to-back loads.
        load         = 1'b1;
        Upper_4_PC   = 4'h1;
        Lower_12_Imm = 12'h234;
        cycle();
        chk("b2b_q0", Target_Q, 16'h1234);
        Upper_4_PC   = 4'h2;
        Lower_12_Imm = 12'h345;
        cycle();
        chk("b2b_q1", Target_Q, 16'h2345);

        // Several idle cycles: value and valid remain sticky.
        load         = 1'b0;
        Upper_4_PC   = 4'h7;
        Lower_12_Imm = 12'h777;
        cycle();
        cycle();
        chk("idle_q",   Target_Q, 16'h2345);
        chk("idle_vld", {15'd0, Target_Valid}, 16'h0001);

        // Reset and load on the same edge: reset wins.
        reset        = 1'b1;
        load         = 1'b1;
        Upper_4_PC   = 4'hC;
        Lower_12_Imm = 12'hDEF;
        cycle();
        chk("rl_q",    Target_Q, 16'h0000);
        chk("rl_vld",  {15'd0, Target_Valid}, 16'h0000);
        chk("rl_comb", Append_Out, 16'hCDEF);

        // Valid stays low after reset until a load occurs.
        reset = 1'b0;
        load  = 1'b0;
        cycle();
        chk("post_rst_vld", {15'd0, Target_Valid}, 16'h0000);
        chk("post_rst_q",   Target_Q, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_append_buffer

// File: doc/append_buffer.md
Name: append_buffer

Overview:
- Jump-target address former for the 16-bit processor.
- Concatenates the upper 4 bits of the PC with the 12-bit immediate from the jump instruction to produce the 16-bit target.
- The combinational target feeds the PC-select mux directly.
- An optional registered copy, with a valid flag, is provided for pipelined or multi-cycle use.

Parameters:
- HI_W, 4, width of the PC-derived upper field.
- IMM_W, 12, width of the immediate lower field.
- ADDR_W, 16, output address width. HI_W + IMM_W must equal ADDR_W; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture enable for the registered target.
- Upper_4_PC  input  HI_W (4)  upper bits of the current PC.
- Lower_12_Imm  input  IMM_W (12)  immediate field of the instruction.
- Append_Out  output  ADDR_W (16)  combinational target {Upper_4_PC, Lower_12_Imm}.
- Target_Q  output  ADDR_W (16)  registered target.
- Target_Valid  output  1  high once a target has been captured since reset.

Interface:
- One clock; reset is synchronous and active-high.
- Clock port is clk and reset port is reset.
- Polarity and synchronicity are fixed.

Behaviour:
- Append_Out[15:12] = Upper_4_PC and Append_Out[11:0] = Lower_12_Imm.
- Append_Out is purely combinational with zero latency.
- Append_Out is independent of clk, reset and load. It is valid with no clock running and while clk/reset/load are unconnected.
- No sign extension, no arithmetic, no truncation: every input bit maps to exactly one output bit.
- Registered path, evaluated on the rising edge of clk:
  - If reset = 1: Target_Q <= 0x0000 and Target_Valid <= 0. Reset wins over a simultaneous load.
  - Else if load = 1: Target_Q <= {Upper_4_PC, Lower_12_Imm} as sampled at that edge, and Target_Valid <= 1.
  - Else: Target_Q and Target_Valid hold.
- Target_Q updates 1 cycle after load is sampled.
- Back-to-back loads capture a new value every cycle.
- Target_Valid stays 1 until the next reset. There is no clear-on-read.
- Reset values: Target_Q = 0x0000, Target_Valid = 0. Append_Out has no reset value; it always reflects the inputs.
- Registered outputs are defined only when load and reset are driven. The combinational path has no such dependency.

Decomposition:
- Shared package: ADDR_W, HI_W and IMM_W constants, plus an addr_t typedef of ADDR_W bits, reused by the PC and branch logic.
- One small sub-module is natural: append_concat, the combinational concatenation, instantiated here and reusable by the branch-target logic.
- The register stage stays in append_buffer.

Test Plan:
- Upper_4_PC = 0, Lower_12_Imm = 0x000, no clock -> Append_Out = 0x0000.
- Upper_4_PC = 4, Lower_12_Imm = 0x567, no clock -> Append_Out = 0x4567 within 10 ns.
- Bit isolation: (0xA, 0x000) -> 0xA000; (0x0, 0xABC) -> 0x0ABC; (0xF, 0xFFF) -> 0xFFFF; (0x5, 0xAAA) -> 0x5AAA.
- Reset high for 2 cycles -> Target_Q = 0x0000, Target_Valid = 0. Then load = 1 with (0x3, 0x21F) for one edge -> next cycle Target_Q = 0x321F, Target_Valid = 1.
- After capture, change inputs to (0x9, 0x001) with load = 0 -> Target_Q holds 0x321F while Append_Out = 0x9001 immediately.
- reset = 1 and load = 1 on the same edge with (0xC, 0xDEF) -> Target_Q = 0x0000, Target_Valid = 0, Append_Out = 0xCDEF.
